// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the instruction memory of the single-cycle MIPS datapath.
// Consumes a byte stream (valid/ready), reads a 16-bit big-endian word count,
// then assembles big-endian 32-bit instruction words and writes them to the
// instruction memory at consecutive word addresses starting at BASE_ADDR.
// The CPU is held (cpu_hold = 1) until a complete image has been accepted.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   a trailing XOR checksum byte over all data bytes is verified before the
//   loader reports done; a mismatch ends in the error state.
//
// Parameters
//   DEPTH_WORDS : instruction-memory capacity in words (1..65535)
//   BASE_ADDR   : byte address of word 0 (4-byte aligned)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a load (honoured in IDLE, DONE, ERR only)
//   in_valid   in   in_data carries a byte
//   in_data    in   [7:0] stream byte
//   in_ready   out  loader accepts a byte this cycle
//   imem_we    out  instruction-memory write strobe (one cycle per word)
//   imem_waddr out  [31:0] byte address of the write
//   imem_wdata out  [31:0] instruction word
//   cpu_hold   out  stall PC/CPU while high
//   done       out  load completed successfully (level)
//   err        out  load rejected (level)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] asm_q, asm_d;     // first three bytes of the word in flight
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_w;
  logic [31:0] word_off;

  assign accept   = in_valid & in_ready;
  // Word count as it becomes known on the LEN_LO byte.
  assign n_w      = {len_hi_q, in_data};
  assign word_off = {14'd0, idx_q, 2'b00};

  // Handshake and status outputs are pure decodes of the registered state,
  // so cpu_hold/done/err change on the same edge that enters DONE or ERR.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = 16'd0;
          bcnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = n_w;
          if (n_w == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({16'd0, n_w} > DEPTH_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {asm_q[15:0], in_data};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = BASE_ADDR + word_off;
            wdata_d = {asm_q, in_data};
            idx_d   = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      bcnt_q   <= 2'd0;
      asm_q    <= 24'd0;
      we_q     <= 1'b0;
      waddr_q  <= 32'd0;
      wdata_q  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Testbench for imem_loader. Streams byte images into the loader, records every
// instruction-memory write, and compares against a reference model that derives
// the expected writes and final status directly from the byte stream.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [63:0] wr_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  wr_q_t wq;

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is one write; a stretched strobe shows
  // up as extra entries.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what memory should contain and how the load should end,
  // computed from the stream alone.
  task automatic model(input byte_q_t s, output wr_q_t w, output bit e_done, output bit e_err);
    int n;
    logic [7:0] x;
    w = {};
    n = {s[0], s[1]};
    if (n > DEPTH) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      w.push_back({BASE + 32'(4 * i), s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int i = 0; i < 4 * n; i++) x = x ^ s[2+i];
    e_err  = (x != s[2+4*n]);
    e_done = !e_err;
`else
    x = 8'd0;
    e_done = (x == 8'd0);
    e_err  = 1'b0;
`endif
  endtask

  // Builds a well-formed stream; an oversize count carries only its length
  // bytes because the loader stops accepting after them.
  task automatic build(input int n, input word_q_t words, output byte_q_t s);
    logic [7:0] x;
    logic [31:0] wd;
    s = {};
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n > DEPTH) return;
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      wd = words[i];
      for (int b = 3; b >= 0; b--) begin
        s.push_back(wd[8*b +: 8]);
        x = x ^ wd[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      check("in_ready_wait", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready},   64'd0);
    check({tag, "_we"},       {63'd0, imem_we},    64'd0);
    check({tag, "_waddr"},    {32'd0, imem_waddr}, 64'd0);
    check({tag, "_wdata"},    {32'd0, imem_wdata}, 64'd0);
    check({tag, "_hold"},     {63'd0, cpu_hold},   64'd1);
    check({tag, "_done"},     {63'd0, done},       64'd0);
    check({tag, "_err"},      {63'd0, err},        64'd0);
  endtask

  // Full load: start, stream (optionally with a start pulse injected before
  // byte mid_idx), then compare writes and final status with the model.
  task automatic run_load(input string tag, input byte_q_t s, input int gap_mode, input int mid_idx);
    wr_q_t ew;
    bit ed, ee;
    model(s, ew, ed, ee);
    wq = {};
    pulse_start();
    foreach (s[i]) begin
      if (i == mid_idx) pulse_start();
      send_byte(s[i], gap_of(gap_mode));
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(ew.size()));
    foreach (ew[i]) if (i < wq.size()) check({tag, "_write"}, wq[i], ew[i]);
    check({tag, "_done"},     {63'd0, done},     {63'd0, ed});
    check({tag, "_err"},      {63'd0, err},      {63'd0, ee});
    check({tag, "_hold"},     {63'd0, cpu_hold}, {63'd0, ~ed});
    check({tag, "_we_low"},   {63'd0, imem_we},  64'd0);
    check({tag, "_ready_lo"}, {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    byte_q_t s;
    word_q_t w;
    int n;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Example image from the datasheet, back-to-back and with gaps.
    w = '{32'h2008_0005, 32'hAC0A_0004};
    build(2, w, s);
    run_load("n2", s, 0, -1);
    run_load("n2_toggle", s, 1, -1);

    // Oversize count, then recovery.
    build(65, w, s);
    run_load("n65", s, 0, -1);
    build(2, w, s);
    run_load("recover", s, 0, -1);

    // Empty image.
    build(0, w, s);
    run_load("n0", s, 0, -1);

    // Exact capacity.
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    build(DEPTH, w, s);
    run_load("n_full", s, 2, -1);

    // start in the middle of the data is ignored.
    w = '{32'h2008_0005, 32'hAC0A_0004};
    build(2, w, s);
    run_load("mid_start", s, 0, 6);

    // Reset after 5 of 8 data bytes.
    wq = {};
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(s[i], 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_writes", 64'(wq.size()), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load("after_reset", s, 0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h1234_5678};
    build(1, w, s);
    run_load("csum_good", s, 0, -1);
    s[s.size()-1] = 8'h09;
    run_load("csum_bad", s, 0, -1);
`endif

    // Randomized images.
    for (int k = 0; k < 12; k++) begin
      w = {};
      if (k % 5 == 4) n = int'($urandom_range(65, 65535));
      else            n = int'($urandom_range(1, 6));
      for (int i = 0; i < n && i < DEPTH; i++) w.push_back($urandom);
      build(n, w, s);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (k % 4 == 3 && n <= DEPTH) s[s.size()-1] = s[s.size()-1] ^ 8'(1 << (k % 8));
`endif
      run_load("rand", s, 2, (k % 3 == 0) ? 3 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
